utx_buf: RTL and testbench
==========================

UTX_BUF -- requirements
Module: utx_buf

Interface
REQ-001 SHALL have parameter GAP_US, default 104, meaning the minimum count of pluse_us strobes between successive tx_vld pulses (must be at least 100).
REQ-002 SHALL have parameter DEPTH, default 16, meaning the FIFO depth in bytes (power of two).
REQ-003 clk_sys  input  1  system clock; reset rst_n, asynchronous, active-low; clock clk_sys.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 pluse_us  input  1  one-cycle strobe, once per microsecond.
REQ-006 wr_data  input  8  byte to queue.
REQ-007 wr_en  input  1  write request, one byte per cycle.
REQ-008 wr_full  output  1  FIFO holds DEPTH bytes.
REQ-009 wr_cnt  output  5  FIFO occupancy, 0..16.
REQ-010 clr_err  input  1  clears ovf_err.
REQ-011 ovf_err  output  1  sticky flag: a write was dropped.
REQ-012 tx_data  output  8  byte to the UART TX phy.
REQ-013 tx_vld  output  1  one-cycle launch strobe to the UART TX phy.
REQ-014 tx_busy  output  1  a byte is queued or a frame gap is running.

Function
REQ-015 Write acceptance SHALL be exactly wr_en and not wr_full, evaluated on the current registered count.
REQ-016 wr_full SHALL equal (wr_cnt == DEPTH).
REQ-017 Next count SHALL equal count + push - pop; simultaneous push and pop leaves the count unchanged.
REQ-018 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; byte order SHALL be preserved across the wrap.
REQ-019 The state machine SHALL have three states:
- IDLE: go to LOAD when count is non-zero.
- LOAD: lasts one cycle; pop the head into tx_data, clear gap_cnt, go to WAIT.
- WAIT: gap_cnt increments on each pluse_us; on a pluse_us with gap_cnt == GAP_US-1, go to IDLE.
REQ-020 tx_vld SHALL be 1 exactly in the LOAD cycle, and tx_data SHALL be valid in that same cycle.
REQ-021 tx_data SHALL hold its value until the next LOAD.
REQ-022 A byte written in cycle k into an empty FIFO while in IDLE SHALL produce tx_vld in cycle k+2.
REQ-023 Successive tx_vld pulses SHALL be separated by GAP_US pluse_us strobes plus 2 clk_sys cycles; the 100-us frame of the UART TX phy is never overrun.
REQ-024 A pluse_us strobe during LOAD SHALL be ignored.
REQ-025 gap_cnt SHALL be 7 bits wide.
REQ-026 A write attempted while full SHALL be dropped, with FIFO contents unchanged, and ovf_err SHALL be set the next cycle.
REQ-027 If a set and clr_err occur in the same cycle, set wins.
REQ-028 clr_err alone SHALL clear ovf_err the next cycle.
REQ-029 tx_busy SHALL equal (state != IDLE) or (count != 0).

Reset
REQ-030 On rst_n low:
- state = IDLE; pointers, count and gap_cnt = 0.
- tx_vld = 0, tx_data = 8'h00, ovf_err = 0, wr_full = 0, wr_cnt = 0, tx_busy = 0.
REQ-031 A reset mid-operation SHALL discard all queued bytes; no tx_vld SHALL follow reset release until a new write.
REQ-032 FIFO storage SHALL need no reset.

Structure
REQ-033 The shared commu package SHALL hold DEPTH, the address width (4), GAP_US, and the state encoding (IDLE, LOAD, WAIT).
REQ-034 Storage and pointers SHALL sit in one sub-module, utx_fifo (synchronous 16x8, push/pop, count); the sequencer stays in utx_buf.

Verification
REQ-035 Single byte: write 0x3C in cycle k into an empty FIFO -> tx_vld=1 in cycle k+2 with tx_data=0x3C; tx_busy falls 104 pluse_us later, plus 1 cycle.
REQ-036 Burst: write 0xA1, 0xA2, 0xA3 back-to-back -> three tx_vld pulses in order, each spaced 104 pluse_us plus 2 cycles; wr_cnt reads 1,2,2,...
REQ-037 Overflow, with pluse_us held low:
- Stimulus: write 0x00..0x11 on consecutive cycles.
- 0x00 is launched; wr_full=1 after 0x10; 0x11 is dropped; ovf_err=1; wr_cnt=16.
- Then release pluse_us -> 0x01..0x10 are emitted in order.
REQ-038 Error clear: clr_err in the same cycle as a dropped write -> ovf_err stays 1; clr_err alone -> ovf_err=0 the next cycle.
REQ-039 Reset in WAIT with 5 bytes queued -> all outputs equal reset values; no tx_vld after release.
REQ-040 Wrap: 40 sequential bytes 0x00..0x27, writes throttled so wr_full never asserts -> emitted order 0x00..0x27 exactly, with no loss.

Source files
------------

// File: rtl/commu_pkg.sv
// Shared constants and sequencer state encoding for the UART TX byte buffer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package commu_pkg;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int GAP_US = 104;
    localparam int GAP_W  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_state_e;
endpackage

// File: rtl/utx_fifo.sv
// Synchronous byte FIFO with occupancy count; head is readable combinationally.
// Latency: a pushed byte is visible at the head the cycle after the push.
// Backpressure: full_o; pushes while full are ignored, pops while empty are ignored.
module utx_fifo #(
    parameter int DEPTH = commu_pkg::DEPTH,
    parameter int AW    = commu_pkg::AW
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic [AW:0]   cnt_o,
    output logic          full_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == FULL_CNT);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (cnt_q != '0);
    assign cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    assign cnt_o   = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_sys) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/utx_buf.sv
// Queues bytes and launches them to the UART TX phy with a minimum microsecond gap.
// Latency: byte written into an empty idle buffer in cycle k gives tx_vld in cycle k+2.
// Backpressure: wr_full; writes while full are dropped and latched in sticky ovf_err.
module utx_buf
    import commu_pkg::tx_state_e, commu_pkg::IDLE, commu_pkg::LOAD, commu_pkg::WAIT,
           commu_pkg::GAP_W;
#(
    parameter int GAP_US = commu_pkg::GAP_US,
    parameter int DEPTH  = commu_pkg::DEPTH
) (
    input  logic                     clk_sys,
    input  logic                     rst_n,
    input  logic                     pluse_us,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    output logic                     wr_full,
    output logic [$clog2(DEPTH):0]   wr_cnt,
    input  logic                     clr_err,
    output logic                     ovf_err,
    output logic [7:0]               tx_data,
    output logic                     tx_vld,
    output logic                     tx_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_US - 1);

    tx_state_e        state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             ovf_q, ovf_d;
    logic             pop;
    logic [7:0]       fifo_head;
    logic [AW:0]      fifo_cnt;
    logic             fifo_full;

    utx_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .push_i  (wr_en),
        .wdata_i (wr_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .cnt_o   (fifo_cnt),
        .full_o  (fifo_full)
    );

    // tx_data is captured on entry to LOAD so it is already valid during the strobe.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        tx_data_d = tx_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_cnt != '0) begin
                    state_d   = LOAD;
                    tx_data_d = fifo_head;
                end
            end
            LOAD: begin
                pop       = 1'b1;
                gap_cnt_d = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (pluse_us) begin
                    if (gap_cnt_q == GAP_LAST) state_d = IDLE;
                    else                       gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Set beats clear when a drop and clr_err coincide.
    assign ovf_d = (wr_en && fifo_full) ? 1'b1 : (clr_err ? 1'b0 : ovf_q);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            tx_data_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            tx_data_q <= tx_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign wr_full = fifo_full;
    assign wr_cnt  = fifo_cnt;
    assign ovf_err = ovf_q;
    assign tx_data = tx_data_q;
    assign tx_vld  = (state_q == LOAD);
    assign tx_busy = (state_q != IDLE) || (fifo_cnt != '0);
endmodule

// File: tb/tb_utx_buf.sv
// Bench for utx_buf: queue-based launch/gap reference model plus directed scenarios.
module tb_utx_buf;
    localparam int GAP   = 104;
    localparam int DEPTH = 16;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       pluse_us = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic       wr_full, ovf_err, tx_vld, tx_busy;
    logic [4:0] wr_cnt;
    logic [7:0] tx_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    bit pulse_en = 1'b0;

    // reference model state
    logic [7:0] mq[$];
    bit         m_launch, m_gap, m_ovf;
    int         m_pulses;
    logic [7:0] m_data;
    int         m_accepted = 0;

    // observation logs
    logic [7:0] emit_q[$];
    int         vld_cyc[$];
    int         pulse_cyc[$];
    bit         full_seen;
    bit         prev_busy;
    int         idle_cyc;

    utx_buf #(.GAP_US(GAP), .DEPTH(DEPTH)) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .pluse_us (pluse_us),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .wr_full  (wr_full),
        .wr_cnt   (wr_cnt),
        .clr_err  (clr_err),
        .ovf_err  (ovf_err),
        .tx_data  (tx_data),
        .tx_vld   (tx_vld),
        .tx_busy  (tx_busy)
    );

    initial forever #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cycle = cycle + 1;

    always @(posedge clk_sys) begin
        #1;
        pluse_us = pulse_en && (cycle % 3 == 0);
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d required < 150000", cycle);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!tx_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
    endtask

    function automatic int nth_pulse_after(input int t, input int n);
        int seen;
        seen = 0;
        foreach (pulse_cyc[i]) begin
            if (pulse_cyc[i] > t) begin
                seen++;
                if (seen == n) return pulse_cyc[i];
            end
        end
        return -1;
    endfunction

    // Launch rules: a byte present while idle launches next cycle; each launch
    // opens a gap of GAP strobes (strobe in the launch cycle itself not counted).
    task automatic run_model();
        bit accept, drop, nxt_launch, exp_busy;
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                n_tests++;
                if (tx_vld !== 1'b0 || tx_data !== 8'h00 || wr_cnt !== 5'd0 ||
                    wr_full !== 1'b0 || ovf_err !== 1'b0 || tx_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL model_reset cyc=%0d vld=%b data=%h cnt=%0d full=%b ovf=%b busy=%b required all zero",
                             cycle, tx_vld, tx_data, wr_cnt, wr_full, ovf_err, tx_busy);
                end
                mq.delete();
                m_launch = 0; m_gap = 0; m_pulses = 0; m_ovf = 0; m_data = 8'h00;
                prev_busy = 0;
            end else begin
                if (m_launch && mq.size() > 0) m_data = mq[0];
                exp_busy = m_launch || m_gap || (mq.size() != 0);
                n_tests++;
                if (tx_vld !== m_launch) begin
                    n_fail++;
                    $display("FAIL model_tx_vld cyc=%0d got %b expected %b", cycle, tx_vld, m_launch);
                end
                n_tests++;
                if (tx_data !== m_data) begin
                    n_fail++;
                    $display("FAIL model_tx_data cyc=%0d got %h expected %h", cycle, tx_data, m_data);
                end
                n_tests++;
                if (wr_cnt !== 5'(mq.size())) begin
                    n_fail++;
                    $display("FAIL model_wr_cnt cyc=%0d got %0d expected %0d", cycle, wr_cnt, mq.size());
                end
                n_tests++;
                if (wr_full !== (mq.size() == DEPTH)) begin
                    n_fail++;
                    $display("FAIL model_wr_full cyc=%0d got %b expected %b", cycle, wr_full, mq.size() == DEPTH);
                end
                n_tests++;
                if (ovf_err !== m_ovf) begin
                    n_fail++;
                    $display("FAIL model_ovf_err cyc=%0d got %b expected %b", cycle, ovf_err, m_ovf);
                end
                n_tests++;
                if (tx_busy !== exp_busy) begin
                    n_fail++;
                    $display("FAIL model_tx_busy cyc=%0d got %b expected %b", cycle, tx_busy, exp_busy);
                end

                if (tx_vld === 1'b1) begin
                    emit_q.push_back(tx_data);
                    vld_cyc.push_back(cycle);
                end
                if (pluse_us) pulse_cyc.push_back(cycle);
                if (wr_full === 1'b1) full_seen = 1'b1;
                if (prev_busy && tx_busy === 1'b0) idle_cyc = cycle;
                prev_busy = (tx_busy === 1'b1);

                accept     = wr_en && (mq.size() < DEPTH);
                drop       = wr_en && !accept;
                nxt_launch = !m_launch && !m_gap && (mq.size() != 0);
                if (m_launch) begin
                    if (mq.size() > 0) void'(mq.pop_front());
                    m_gap    = 1'b1;
                    m_pulses = 0;
                end else if (m_gap && pluse_us) begin
                    m_pulses++;
                    if (m_pulses == GAP) m_gap = 1'b0;
                end
                if (accept) begin
                    mq.push_back(wr_data);
                    m_accepted++;
                end
                m_launch = nxt_launch;
                m_ovf    = drop ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk_sys);
        n_tests++;
        if (tx_vld !== 1'b0 || tx_data !== 8'h00 || wr_cnt !== 5'd0 ||
            wr_full !== 1'b0 || ovf_err !== 1'b0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values vld=%b data=%h cnt=%0d full=%b ovf=%b busy=%b required all zero",
                     tx_vld, tx_data, wr_cnt, wr_full, ovf_err, tx_busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int k, n0, p;
        bit ok;
        pulse_en = 1'b1;
        n0 = vld_cyc.size();
        k  = cycle;
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (vld_cyc.size() <= n0) begin
            n_fail++;
            $display("FAIL single_launch no tx_vld seen, required at cycle %0d", k + 2);
        end else begin
            if (vld_cyc[n0] !== k + 2 || emit_q[n0] !== 8'h3C) begin
                n_fail++;
                $display("FAIL single_launch got cyc %0d data %h, required cyc %0d data 3c",
                         vld_cyc[n0], emit_q[n0], k + 2);
            end
            wait_idle(1000, ok);
            p = nth_pulse_after(vld_cyc[n0], GAP);
            n_tests++;
            if (!ok || idle_cyc !== p + 1) begin
                n_fail++;
                $display("FAIL single_busy_fall got cyc %0d (ok=%b), required %0d", idle_cyc, ok, p + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n0, p;
        bit ok;
        logic [7:0] exp_b [3];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3;
        n0 = vld_cyc.size();
        wr_en = 1'b1; wr_data = 8'hA1;
        tick();
        wr_data = 8'hA2;
        n_tests++;
        if (wr_cnt !== 5'd1) begin
            n_fail++; $display("FAIL burst_cnt0 got %0d required 1", wr_cnt);
        end
        tick();
        wr_data = 8'hA3;
        n_tests++;
        if (wr_cnt !== 5'd2) begin
            n_fail++; $display("FAIL burst_cnt1 got %0d required 2", wr_cnt);
        end
        tick();
        wr_en = 1'b0;
        n_tests++;
        if (wr_cnt !== 5'd2) begin
            n_fail++; $display("FAIL burst_cnt2 got %0d required 2", wr_cnt);
        end
        wait_idle(2000, ok);
        n_tests++;
        if (!ok || vld_cyc.size() != n0 + 3) begin
            n_fail++;
            $display("FAIL burst_count got %0d launches (ok=%b) required 3", vld_cyc.size() - n0, ok);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (emit_q[n0+i] !== exp_b[i]) begin
                    n_fail++;
                    $display("FAIL burst_order idx %0d got %h required %h", i, emit_q[n0+i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                p = nth_pulse_after(vld_cyc[n0+i-1], GAP);
                n_tests++;
                if (vld_cyc[n0+i] !== p + 2) begin
                    n_fail++;
                    $display("FAIL burst_spacing idx %0d got cyc %0d required %0d", i, vld_cyc[n0+i], p + 2);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int n0;
        bit ok;
        pulse_en = 1'b0;
        n0 = emit_q.size();
        for (int i = 0; i < 18; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            if (i == 17) begin
                n_tests++;
                if (wr_full !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_full got %b required 1", wr_full);
                end
            end
            tick();
        end
        wr_en = 1'b0;
        n_tests++;
        if (ovf_err !== 1'b1 || wr_cnt !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_flag got ovf=%b cnt=%0d required ovf=1 cnt=16", ovf_err, wr_cnt);
        end
        n_tests++;
        if (emit_q.size() != n0 + 1 || emit_q[n0] !== 8'h00) begin
            n_fail++;
            $display("FAIL ovf_first got %0d launches, required one launch of 00", emit_q.size() - n0);
        end
        pulse_en = 1'b1;
        wait_idle(8000, ok);
        n_tests++;
        if (!ok || emit_q.size() != n0 + 17) begin
            n_fail++;
            $display("FAIL ovf_drain got %0d bytes (ok=%b) required 17", emit_q.size() - n0, ok);
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_tests++;
                if (emit_q[n0+i] !== 8'(i)) begin
                    n_fail++;
                    $display("FAIL ovf_order idx %0d got %h required %h", i, emit_q[n0+i], 8'(i));
                end
            end
        end
    endtask

    task automatic test_err_clear();
        bit ok;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_tests++;
        if (ovf_err !== 1'b0) begin
            n_fail++; $display("FAIL clr_first got %b required 0", ovf_err);
        end
        pulse_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h50 + i);
            tick();
        end
        wr_en = 1'b1; wr_data = 8'hEE; clr_err = 1'b1;
        tick();
        wr_en = 1'b0; clr_err = 1'b0;
        n_tests++;
        if (ovf_err !== 1'b1) begin
            n_fail++; $display("FAIL clr_set_wins got %b required 1", ovf_err);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_tests++;
        if (ovf_err !== 1'b0) begin
            n_fail++; $display("FAIL clr_alone got %b required 0", ovf_err);
        end
        pulse_en = 1'b1;
        wait_idle(8000, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL clr_drain timeout busy=%b required 0", tx_busy);
        end
    endtask

    task automatic test_reset_wait();
        int n0;
        pulse_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (wr_cnt !== 5'd5 || tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_pre got cnt=%0d busy=%b required cnt=5 busy=1", wr_cnt, tx_busy);
        end
        rst_n = 1'b0;
        @(negedge clk_sys);
        n_tests++;
        if (tx_vld !== 1'b0 || tx_data !== 8'h00 || wr_cnt !== 5'd0 ||
            wr_full !== 1'b0 || ovf_err !== 1'b0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_values vld=%b data=%h cnt=%0d full=%b ovf=%b busy=%b required all zero",
                     tx_vld, tx_data, wr_cnt, wr_full, ovf_err, tx_busy);
        end
        tick();
        rst_n = 1'b1;
        pulse_en = 1'b1;
        n0 = vld_cyc.size();
        repeat (400) tick();
        n_tests++;
        if (vld_cyc.size() != n0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_quiet got %0d launches busy=%b required 0 launches busy=0",
                     vld_cyc.size() - n0, tx_busy);
        end
    endtask

    task automatic test_wrap();
        int n0, sent, guard;
        bit ok;
        n0 = emit_q.size();
        full_seen = 1'b0;
        sent = 0;
        guard = 0;
        while (sent < 40 && guard < 30000) begin
            if (mq.size() < 12) begin
                wr_en = 1'b1; wr_data = 8'(sent);
                sent++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            guard++;
        end
        wr_en = 1'b0;
        wait_idle(20000, ok);
        n_tests++;
        if (!ok || full_seen || emit_q.size() != n0 + 40) begin
            n_fail++;
            $display("FAIL wrap_count got %0d bytes ok=%b full_seen=%b required 40 bytes, never full",
                     emit_q.size() - n0, ok, full_seen);
        end else begin
            for (int i = 0; i < 40; i++) begin
                n_tests++;
                if (emit_q[n0+i] !== 8'(i)) begin
                    n_fail++;
                    $display("FAIL wrap_order idx %0d got %h required %h", i, emit_q[n0+i], 8'(i));
                end
            end
        end
    endtask

    task automatic test_random();
        int n0, acc0;
        bit ok;
        n0 = emit_q.size();
        acc0 = m_accepted;
        pulse_en = 1'b0;
        for (int i = 0; i < 22; i++) begin
            wr_en   = ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom);
            clr_err = ($urandom_range(0, 7) == 0);
            tick();
        end
        pulse_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wr_en   = ($urandom_range(0, 19) == 0);
            wr_data = 8'($urandom);
            clr_err = ($urandom_range(0, 7) == 0);
            tick();
        end
        wr_en = 1'b0; clr_err = 1'b0;
        wait_idle(10000, ok);
        n_tests++;
        if (!ok || (emit_q.size() - n0) != (m_accepted - acc0)) begin
            n_fail++;
            $display("FAIL random_drain got %0d bytes out (ok=%b) required %0d accepted",
                     emit_q.size() - n0, ok, m_accepted - acc0);
        end
    endtask

    initial begin
        fork
            run_model();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_err_clear();
        test_reset_wait();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
